// File: rtl/fwd_pkg.sv
// Shared select encoding and index helpers for the forwarding/hazard unit.
// fsel_t is sized for the default two-stage forwarding depth.
package fwd_pkg;

    localparam int FWD_DEPTH = 2;
    localparam int FSEL_W    = $clog2(FWD_DEPTH + 1);

    typedef logic [FSEL_W-1:0] fsel_t;

    localparam int FSEL_RF = 0;

    // Select code for producer stage k (stage 0 = MEM).
    function automatic int fsel_stage(input int k);
        return k + 1;
    endfunction

    // Bit offset of source operand s inside a packed index vector.
    function automatic int src_lsb(input int s, input int raw);
        return s * raw;
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Per-register busy tracking for multi-cycle MDU results.
// Produces RAW, WAW and structural stall terms from the registered busy state.
module mdu_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_REGS = 32,
    localparam int RAW      = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SRC*RAW-1:0] rs_i,
    input  logic [NUM_SRC-1:0]     rs_used_i,
    input  logic [RAW-1:0]         rd_i,
    input  logic                   wen_i,
    input  logic                   mdu_i,
    input  logic                   issue_i,
    input  logic                   wb_valid_i,
    input  logic [RAW-1:0]         wb_rd_i,
    output logic                   raw_stall_o,
    output logic                   waw_stall_o,
    output logic                   struct_stall_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                mdu_busy_q, mdu_busy_d;

    always_comb begin
        raw_stall_o = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
            if (rs_used_i[s] && busy_q[rs_i[src_lsb(s, RAW) +: RAW]])
                raw_stall_o = 1'b1;
    end

    assign waw_stall_o    = wen_i && busy_q[rd_i];
    assign struct_stall_o = mdu_i && mdu_busy_q && !wb_valid_i;

    // Clear first so a same-cycle issue to the completing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i)
            busy_d[wb_rd_i] = 1'b0;
        if (issue_i && rd_i != '0)
            busy_d[rd_i] = 1'b1;
    end

    assign mdu_busy_d = issue_i || (mdu_busy_q && !wb_valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            mdu_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            mdu_busy_q <= mdu_busy_d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding select generation plus load-use and MDU stall control.
// Selects are resolved in ID and registered so EX only muxes.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_FWD  = 2,
    parameter  int NUM_REGS = 32,
    parameter  int CNT_W    = 32,
    localparam int RAW      = $clog2(NUM_REGS),
    localparam int FSW      = $clog2(NUM_FWD + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   id_valid,
    input  logic [NUM_SRC*RAW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [RAW-1:0]         id_rd,
    input  logic                   id_wen,
    input  logic                   id_mdu,
    input  logic [RAW-1:0]         ex_rd,
    input  logic                   ex_wen,
    input  logic                   ex_is_load,
    input  logic [NUM_FWD*RAW-1:0] stg_rd,
    input  logic [NUM_FWD-1:0]     stg_wen,
    input  logic                   mdu_wb_valid,
    input  logic [RAW-1:0]         mdu_wb_rd,
    input  logic                   flush,
    output logic [NUM_SRC*FSW-1:0] fwd_sel_ex,
    output logic                   stall_id,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [NUM_SRC*FSW-1:0] fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_SRC-1:0]     lu_hit;
    logic                   load_use, raw_stall, waw_stall, struct_stall, issue;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [RAW-1:0] rs;
        logic [FSW-1:0] nsel;

        assign rs        = id_rs[src_lsb(s, RAW) +: RAW];
        assign lu_hit[s] = id_rs_used[s] && (rs == ex_rd);

        // EX lands in stage 0 by the time ID executes; the last stage has
        // already written the register file, so it is never selected.
        always_comb begin
            nsel = FSW'(FSEL_RF);
            if (id_rs_used[s] && rs != '0) begin
                if (ex_wen && ex_rd == rs)
                    nsel = FSW'(fsel_stage(0));
                else
                    for (int k = NUM_FWD - 2; k >= 0; k--)
                        if (stg_wen[k] && stg_rd[k*RAW +: RAW] == rs)
                            nsel = FSW'(fsel_stage(k + 1));
            end
        end

        assign fwd_sel_d[s*FSW +: FSW] = nsel;
    end

    assign load_use = ex_is_load && ex_wen && (ex_rd != '0) && (|lu_hit);
    assign stall_id = id_valid && !flush &&
                      (load_use || raw_stall || waw_stall || struct_stall);
    assign issue    = id_valid && id_mdu && !stall_id && !flush;

    mdu_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk_i          (i_clk),
        .rst_i          (i_reset),
        .rs_i           (id_rs),
        .rs_used_i      (id_rs_used),
        .rd_i           (id_rd),
        .wen_i          (id_wen),
        .mdu_i          (id_mdu),
        .issue_i        (issue),
        .wb_valid_i     (mdu_wb_valid),
        .wb_rd_i        (mdu_wb_rd),
        .raw_stall_o    (raw_stall),
        .waw_stall_o    (waw_stall),
        .struct_stall_o (struct_stall)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fwd_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            fwd_sel_q <= (flush || stall_id || !id_valid) ? '0 : fwd_sel_d;
            if (stall_id && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fwd_sel_ex = fwd_sel_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table vectors, directed multi-cycle sequences and a randomized run checked
// against a register-level behavioural model of the hazard rules.
module tb_fwd_hazard_unit;

    localparam int NS  = 2;
    localparam int NF  = 2;
    localparam int NR  = 32;
    localparam int RAW = 5;
    localparam int CW  = 4;
    localparam int FSW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              id_valid;
    logic [NS*RAW-1:0] id_rs;
    logic [NS-1:0]     id_rs_used;
    logic [RAW-1:0]    id_rd;
    logic              id_wen;
    logic              id_mdu;
    logic [RAW-1:0]    ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [NF*RAW-1:0] stg_rd;
    logic [NF-1:0]     stg_wen;
    logic              mdu_wb_valid;
    logic [RAW-1:0]    mdu_wb_rd;
    logic              flush;
    logic [NS*FSW-1:0] fwd_sel_ex;
    logic              stall_id;
    logic [CW-1:0]     stall_cnt;

    fwd_hazard_unit #(
        .NUM_SRC (NS), .NUM_FWD (NF), .NUM_REGS (NR), .CNT_W (CW)
    ) dut (
        .i_clk (i_clk), .i_reset (i_reset), .id_valid (id_valid), .id_rs (id_rs),
        .id_rs_used (id_rs_used), .id_rd (id_rd), .id_wen (id_wen), .id_mdu (id_mdu),
        .ex_rd (ex_rd), .ex_wen (ex_wen), .ex_is_load (ex_is_load), .stg_rd (stg_rd),
        .stg_wen (stg_wen), .mdu_wb_valid (mdu_wb_valid), .mdu_wb_rd (mdu_wb_rd),
        .flush (flush), .fwd_sel_ex (fwd_sel_ex), .stall_id (stall_id), .stall_cnt (stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: register busy flags, MDU occupancy, selects, stall count.
    bit m_busy[NR];
    bit m_mdu;
    int m_cnt;
    int m_sel[NS];
    bit m_last_issue;
    int s_stall;

    typedef struct {
        int rs0, rs1, used, ex_rd, ex_wen, ex_ld, s0_rd, s0_wen, s1_rd, s1_wen;
        int stall, sel0, sel1;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rsv(input int s);
        logic [NS*RAW-1:0] v;
        v = id_rs;
        return int'(v[s*RAW +: RAW]);
    endfunction

    function automatic int stage_rd(input int k);
        logic [NF*RAW-1:0] v;
        v = stg_rd;
        return int'(v[k*RAW +: RAW]);
    endfunction

    function automatic int sel_of(input int s);
        logic [NS*FSW-1:0] v;
        v = fwd_sel_ex;
        return int'(v[s*FSW +: FSW]);
    endfunction

    // Where the youngest writer of the operand will sit when this instruction executes.
    function automatic int model_sel(input int s);
        int r;
        r = rsv(s);
        if (!id_rs_used[s] || r == 0) return 0;
        if (ex_wen && int'(ex_rd) == r) return 1;
        for (int k = 0; k < NF - 1; k++)
            if (stg_wen[k] && stage_rd(k) == r) return k + 2;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_mdu = 1'b0;
        m_cnt = 0;
        for (int s = 0; s < NS; s++) m_sel[s] = 0;
        m_last_issue = 1'b0;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wen = 0; id_mdu = 0;
        ex_rd = '0; ex_wen = 0; ex_is_load = 0; stg_rd = '0; stg_wen = '0;
        mdu_wb_valid = 0; mdu_wb_rd = '0; flush = 0;
    endtask

    task automatic set_id(input int r0, input int r1, input int used, input int rd,
                          input int wen, input int mdu);
        id_valid = 1;
        id_rs = {RAW'(r1), RAW'(r0)};
        id_rs_used = NS'(used);
        id_rd = RAW'(rd);
        id_wen = wen[0];
        id_mdu = mdu[0];
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic tick(input string tag);
        bit lu, rw, ww, st, exp_stall, iss;
        int nsel[NS];
        int r;
        @(negedge i_clk);
        lu = 0; rw = 0;
        for (int s = 0; s < NS; s++) begin
            r = rsv(s);
            if (id_rs_used[s]) begin
                if (ex_is_load && ex_wen && ex_rd != 0 && int'(ex_rd) == r) lu = 1;
                if (m_busy[r]) rw = 1;
            end
        end
        ww = id_wen && m_busy[id_rd];
        st = id_mdu && m_mdu && !mdu_wb_valid;
        exp_stall = id_valid && !flush && (lu || rw || ww || st);
        s_stall = int'(stall_id);
        chk({tag, " stall_id"}, int'(stall_id), int'(exp_stall));
        for (int s = 0; s < NS; s++) chk({tag, " fwd_sel"}, sel_of(s), m_sel[s]);
        chk({tag, " stall_cnt"}, int'(stall_cnt), m_cnt);
        for (int s = 0; s < NS; s++) nsel[s] = model_sel(s);
        iss = id_valid && id_mdu && !exp_stall && !flush;
        @(posedge i_clk);
        if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
        if (mdu_wb_valid) m_busy[mdu_wb_rd] = 1'b0;
        if (iss && id_rd != 0) m_busy[id_rd] = 1'b1;
        m_mdu = iss || (m_mdu && !mdu_wb_valid);
        m_last_issue = iss;
        for (int s = 0; s < NS; s++)
            m_sel[s] = (flush || exp_stall || !id_valid) ? 0 : nsel[s];
        #1;
    endtask

    task automatic step_exp(input string tag, input int exp_stall);
        tick(tag);
        chk({tag, " directed stall"}, s_stall, exp_stall);
    endtask

    int out_v, out_rd, out_lat;

    initial begin
        tbl[0]  = '{5,5,3, 5,1,0, 0,0,0,0, 0,1,1};
        tbl[1]  = '{7,7,3, 0,0,0, 7,1,7,1, 0,2,2};
        tbl[2]  = '{0,0,3, 0,1,0, 0,1,0,1, 0,0,0};
        tbl[3]  = '{7,3,3, 0,0,0, 0,0,7,1, 0,0,0};
        tbl[4]  = '{4,4,3, 4,1,0, 4,1,4,1, 0,1,1};
        tbl[5]  = '{3,2,3, 3,1,1, 0,0,0,0, 1,0,0};
        tbl[6]  = '{3,2,2, 3,1,1, 2,1,0,0, 0,0,2};
        tbl[7]  = '{0,0,3, 0,1,1, 0,0,0,0, 0,0,0};
        tbl[8]  = '{6,6,1, 6,0,0, 6,1,0,0, 0,2,0};
        tbl[9]  = '{8,8,3, 0,0,0, 8,0,8,1, 0,0,0};
        tbl[10] = '{9,9,3, 9,0,1, 0,0,0,0, 0,0,0};

        idle_inputs();
        model_clear();
        i_reset = 1;
        #12;
        chk("reset fwd_sel", int'(fwd_sel_ex), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
        chk("reset stall_id", int'(stall_id), 0);
        @(posedge i_clk); #1;
        i_reset = 0;

        // Load-use: one bubble, then the load is in stage 0 and forwards from WB.
        set_id(3, 3, 3, 20, 1, 0);
        ex_rd = 3; ex_wen = 1; ex_is_load = 1;
        chk("lu cnt before", int'(stall_cnt), 0);
        step_exp("lu cycle", 1);
        chk("lu cnt after", int'(stall_cnt), 1);
        ex_wen = 0; ex_is_load = 0; ex_rd = 0;
        stg_rd = {RAW'(0), RAW'(3)}; stg_wen = 2'b01;
        step_exp("lu release", 0);
        chk("lu sel0", sel_of(0), 2);
        chk("lu sel1", sel_of(1), 2);

        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            set_id(tbl[i].rs0, tbl[i].rs1, tbl[i].used, 0, 0, 0);
            ex_rd = RAW'(tbl[i].ex_rd); ex_wen = tbl[i].ex_wen[0]; ex_is_load = tbl[i].ex_ld[0];
            stg_rd = {RAW'(tbl[i].s1_rd), RAW'(tbl[i].s0_rd)};
            stg_wen = {tbl[i].s1_wen[0], tbl[i].s0_wen[0]};
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d stall", i), s_stall, tbl[i].stall);
            chk($sformatf("tbl%0d sel0", i), sel_of(0), tbl[i].sel0);
            chk($sformatf("tbl%0d sel1", i), sel_of(1), tbl[i].sel1);
        end

        // div x9 then add x20,x9,x9: stalls until the cycle after write-back.
        idle_inputs();
        set_id(1, 2, 3, 9, 1, 1);
        step_exp("div9 issue", 0);
        set_id(9, 9, 3, 20, 1, 0);
        for (int i = 0; i < 3; i++) step_exp("raw9 wait", 1);
        mdu_wb_valid = 1; mdu_wb_rd = 9;
        step_exp("raw9 wb", 1);
        mdu_wb_valid = 0;
        step_exp("raw9 release", 0);
        chk("raw9 sel0", sel_of(0), 0);
        chk("raw9 sel1", sel_of(1), 0);

        // Back-to-back MDU ops and same-cycle completion/issue.
        set_id(1, 2, 3, 10, 1, 1);
        step_exp("div10 issue", 0);
        set_id(1, 2, 3, 11, 1, 1);
        step_exp("rem11 struct", 1);
        step_exp("rem11 struct", 1);
        mdu_wb_valid = 1; mdu_wb_rd = 10;
        step_exp("rem11 issue on wb", 0);
        mdu_wb_valid = 0;
        set_id(11, 0, 1, 21, 1, 0);
        step_exp("raw11", 1);
        set_id(0, 0, 0, 12, 1, 1);
        mdu_wb_valid = 1; mdu_wb_rd = 11;
        step_exp("mul12 issue on wb", 0);
        mdu_wb_valid = 0;
        set_id(11, 12, 1, 22, 1, 0);
        step_exp("x11 cleared", 0);
        set_id(11, 12, 2, 22, 1, 0);
        step_exp("x12 busy", 1);
        set_id(0, 0, 0, 13, 1, 1);
        step_exp("mdu busy struct", 1);
        idle_inputs();
        mdu_wb_valid = 1; mdu_wb_rd = 12;
        step_exp("wb12", 0);
        mdu_wb_valid = 0;

        // Flush during a RAW stall: no stall, bubble, scoreboard kept.
        set_id(1, 2, 3, 12, 1, 1);
        step_exp("div12 issue", 0);
        set_id(12, 5, 3, 23, 1, 0);
        ex_rd = 5; ex_wen = 1;
        flush = 1;
        step_exp("flush raw12", 0);
        chk("flush sel0", sel_of(0), 0);
        chk("flush sel1", sel_of(1), 0);
        flush = 0;
        step_exp("raw12 retained", 1);
        mdu_wb_valid = 1; mdu_wb_rd = 12;
        step_exp("raw12 wb", 1);
        mdu_wb_valid = 0;
        step_exp("raw12 release", 0);
        chk("raw12 ex fwd", sel_of(1), 1);

        // Asynchronous reset in the middle of an MDU operation.
        idle_inputs();
        set_id(1, 2, 3, 13, 1, 1);
        step_exp("div13 issue", 0);
        set_id(13, 13, 3, 24, 1, 0);
        @(negedge i_clk); #1;
        chk("pre-reset stall", int'(stall_id), 1);
        i_reset = 1;
        #1;
        chk("async stall_id", int'(stall_id), 0);
        chk("async fwd_sel", int'(fwd_sel_ex), 0);
        chk("async stall_cnt", int'(stall_cnt), 0);
        model_clear();
        id_valid = 0;
        #1 i_reset = 0;
        @(posedge i_clk); #1;
        set_id(13, 13, 3, 24, 1, 0);
        step_exp("post-reset no raw", 0);
        set_id(0, 0, 0, 14, 1, 1);
        step_exp("post-reset no struct", 0);
        idle_inputs();
        mdu_wb_valid = 1; mdu_wb_rd = 14;
        step_exp("wb14", 0);
        mdu_wb_valid = 0;

        // Randomized traffic; the MDU completes a random number of cycles after issue.
        out_v = 0; out_rd = 0; out_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            id_valid   = ($urandom_range(0, 7) != 0);
            id_rs      = {RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7))};
            id_rs_used = NS'($urandom_range(0, 3));
            id_rd      = RAW'($urandom_range(0, 7));
            id_wen     = $urandom_range(0, 1) != 0;
            id_mdu     = ($urandom_range(0, 3) == 0);
            ex_rd      = RAW'($urandom_range(0, 7));
            ex_wen     = $urandom_range(0, 1) != 0;
            ex_is_load = ($urandom_range(0, 2) == 0);
            stg_rd     = {RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7))};
            stg_wen    = NF'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 15) == 0);
            mdu_wb_valid = (out_v != 0) && (out_lat == 0);
            mdu_wb_rd    = RAW'(out_rd);
            tick("rand");
            if (mdu_wb_valid) out_v = 0;
            if (m_last_issue) begin
                out_v = 1; out_rd = int'(id_rd); out_lat = $urandom_range(0, 5);
            end else if (out_v != 0 && out_lat > 0) begin
                out_lat--;
            end
        end
        chk("cnt saturated", int'(stall_cnt), CNT_MAX);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
